// File: rtl/stage_pkg.sv
// Shared definitions for the pipeline stages: default word width and pack FSM states.
package stage_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic {
        PK_LOW  = 1'b0,
        PK_HIGH = 1'b1
    } pack_state_t;

endpackage

// File: rtl/stage_fifo.sv
// Small synchronous FIFO with flush; head is presented combinationally and reads as 0 when empty.
module stage_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + AW'(1);
            if (i_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) mem[wr_ptr] <= i_data;
    end

    assign o_data  = (count != '0) ? mem[rd_ptr] : '0;
    assign o_count = count;

endmodule

// File: rtl/stage_4_pack.sv
// Output packing stage: pairs 16-bit words into 32-bit words and buffers them toward the sink.
// Optional running checksum of popped words is enabled by defining STAGE4_CHECKSUM_EN.
module stage_4_pack
    import stage_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_flush,
    input  logic                i_internal_stall,
    input  logic [DATA_W-1:0]   i_data,
    input  logic                i_valid,
    output logic                o_stall,
    output logic                o_current_ce,
    input  logic                i_stall,
    output logic [2*DATA_W-1:0] o_data,
    output logic                o_valid
`ifdef STAGE4_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]   o_checksum
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    pack_state_t     state_q;
    pack_state_t     state_n;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] lo_n;
    logic [CW-1:0]   count;
    logic            accept;
    logic            push;
    logic            pop;

    // CE depends only on FIFO occupancy and the local stall, never on the sink.
    assign o_current_ce = !i_internal_stall && (count != FULL);
    assign o_stall      = !o_current_ce;
    assign o_valid      = (count != '0);
    assign accept       = i_valid && o_current_ce && !i_flush;
    assign pop          = o_valid && !i_stall && !i_flush;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= PK_LOW;
            lo_q    <= '0;
        end else begin
            state_q <= state_n;
            lo_q    <= lo_n;
        end
    end

    always_comb begin
        state_n = state_q;
        lo_n    = lo_q;
        push    = 1'b0;
        if (i_flush) begin
            state_n = PK_LOW;
            lo_n    = '0;
        end else if (accept) begin
            case (state_q)
                PK_LOW: begin
                    lo_n    = i_data;
                    state_n = PK_HIGH;
                end
                PK_HIGH: begin
                    push    = 1'b1;
                    state_n = PK_LOW;
                end
                default: state_n = PK_LOW;
            endcase
        end
    end

    stage_fifo #(
        .WIDTH (2*DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_flush (i_flush),
        .i_push  (push),
        .i_pop   (pop),
        .i_data  ({i_data, lo_q}),
        .o_data  (o_data),
        .o_count (count)
    );

`ifdef STAGE4_CHECKSUM_EN
    // Flush deliberately leaves the checksum alone; only reset clears it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_checksum <= '0;
        end else if (pop) begin
            o_checksum <= o_checksum + o_data[2*DATA_W-1:DATA_W] + o_data[DATA_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_stage_4_pack.sv
// Self-checking bench for stage_4_pack against a queue-based reference model.
module tb_stage_4_pack;

    localparam int DW    = 16;
    localparam int DEPTH = 2;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_flush;
    logic          i_internal_stall;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_stall;
    logic          o_current_ce;
    logic          i_stall;
    logic [2*DW-1:0] o_data;
    logic          o_valid;
`ifdef STAGE4_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [2*DW-1:0] q[$];
    bit              have_lo;
    logic [DW-1:0]   lo_m;
    logic [DW-1:0]   sum_m;
    bit              last_acc;

    stage_4_pack #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_flush          (i_flush),
        .i_internal_stall (i_internal_stall),
        .i_data           (i_data),
        .i_valid          (i_valid),
        .o_stall          (o_stall),
        .o_current_ce     (o_current_ce),
        .i_stall          (i_stall),
        .o_data           (o_data),
        .o_valid          (o_valid)
`ifdef STAGE4_CHECKSUM_EN
        ,
        .o_checksum       (o_checksum)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        have_lo = 1'b0;
        lo_m    = '0;
        sum_m   = '0;
    endtask

    task automatic check_outputs(input string tag);
        bit exp_ce;
        exp_ce = !i_internal_stall && (q.size() != DEPTH);
        chk({tag, ".ce"},    {31'd0, o_current_ce}, {31'd0, exp_ce});
        chk({tag, ".stall"}, {31'd0, o_stall},      {31'd0, !exp_ce});
        chk({tag, ".valid"}, {31'd0, o_valid},      {31'd0, q.size() != 0});
        chk({tag, ".data"},  o_data,                (q.size() != 0) ? q[0] : '0);
`ifdef STAGE4_CHECKSUM_EN
        chk({tag, ".csum"},  {16'd0, o_checksum},   {16'd0, sum_m});
`endif
    endtask

    // Drive one cycle: inputs applied just after an edge, outputs checked, model advanced at the edge.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit istall, input bit stall,
                        input bit flush, input string tag);
        bit exp_ce;
        i_valid = v; i_data = d; i_internal_stall = istall; i_stall = stall; i_flush = flush;
        #1;
        check_outputs(tag);
        exp_ce = !istall && (q.size() != DEPTH);
        @(posedge i_clk);
        last_acc = 1'b0;
        if (flush) begin
            q.delete();
            have_lo = 1'b0;
            lo_m    = '0;
        end else begin
            last_acc = v && exp_ce;
            if (q.size() != 0 && !stall) begin
                sum_m = sum_m + q[0][2*DW-1:DW] + q[0][DW-1:0];
                void'(q.pop_front());
            end
            if (last_acc) begin
                if (have_lo) begin
                    q.push_back({d, lo_m});
                    have_lo = 1'b0;
                end else begin
                    lo_m    = d;
                    have_lo = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic pulse_reset();
        i_rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async.valid", {31'd0, o_valid}, 32'd0);
        chk("rst_async.data",  o_data, 32'd0);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        int idx;
        logic [DW-1:0] words [6];
        i_rst = 1'b1; i_flush = 0; i_internal_stall = 0; i_data = '0; i_valid = 0; i_stall = 0;
        model_reset();
        #3;
        chk("reset.valid", {31'd0, o_valid}, 32'd0);
        chk("reset.data",  o_data, 32'd0);
        chk("reset.ce",    {31'd0, o_current_ce}, 32'd1);
        chk("reset.stall", {31'd0, o_stall}, 32'd0);
        i_internal_stall = 1'b1;
        #1;
        chk("reset.stall_int", {31'd0, o_stall}, 32'd1);
        i_internal_stall = 1'b0;
`ifdef STAGE4_CHECKSUM_EN
        chk("reset.csum", {16'd0, o_checksum}, 32'd0);
`endif
        #8 i_rst = 1'b0;
        @(posedge i_clk); #1;

        // plain packing
        step(1, 16'h1111, 0, 0, 0, "pack");
        step(1, 16'h2222, 0, 0, 0, "pack");
        chk("pack.word0", o_data, 32'h22221111);
        step(1, 16'h3333, 0, 0, 0, "pack");
        step(1, 16'h4444, 0, 0, 0, "pack");
        chk("pack.word1", o_data, 32'h44443333);
        step(0, 16'h0000, 0, 0, 0, "pack");
        step(0, 16'h0000, 0, 0, 0, "pack");

        // backpressure: upstream holds a word until it is accepted
        for (int i = 0; i < 6; i++) words[i] = DW'(i + 1);
        idx = 0;
        for (int n = 0; n < 30 && idx < 6; n++) begin
            step(1, words[idx], 0, (n < 8), 0, "bp");
            if (last_acc) idx++;
            if (n == 3) chk("bp.stall_full", {31'd0, o_stall}, 32'd1);
        end
        chk("bp.all_accepted", idx, 6);
        for (int n = 0; n < 4; n++) step(0, '0, 0, 0, 0, "bp_drain");

        // flush mid-pair
        step(1, 16'hAAAA, 0, 0, 0, "flush");
        step(0, 16'h0000, 0, 0, 1, "flush");
        step(1, 16'h0B0B, 0, 0, 0, "flush");
        step(1, 16'h0C0C, 0, 0, 0, "flush");
        chk("flush.word", o_data, 32'h0C0C0B0B);
        step(0, 16'h0000, 0, 0, 0, "flush");

        // internal stall blocks acceptance
        for (int n = 0; n < 3; n++) begin
            step(1, 16'h0055, 1, 0, 0, "istall");
            chk("istall.no_accept", {31'd0, last_acc}, 32'd0);
        end
        step(1, 16'h0055, 0, 0, 0, "istall");
        step(1, 16'h0066, 0, 0, 0, "istall");
        chk("istall.word", o_data, 32'h00660055);
        step(0, 16'h0000, 0, 0, 0, "istall");

        // async reset with a buffered word and a held half-word
        step(1, 16'h0009, 0, 1, 0, "arst");
        step(1, 16'h0008, 0, 1, 0, "arst");
        step(1, 16'h1234, 0, 1, 0, "arst");
        pulse_reset();
        step(1, 16'h0001, 0, 0, 0, "arst");
        step(1, 16'h0002, 0, 0, 0, "arst");
        chk("arst.word", o_data, 32'h00020001);
        step(0, 16'h0000, 0, 0, 0, "arst");

`ifdef STAGE4_CHECKSUM_EN
        pulse_reset();
        step(1, 16'h0001, 0, 0, 0, "csum");
        step(1, 16'hFFFF, 0, 0, 0, "csum");
        step(0, 16'h0000, 0, 0, 0, "csum");
        chk("csum.wrap0", {16'd0, o_checksum}, 32'h0000);
        step(1, 16'h0003, 0, 0, 0, "csum");
        step(1, 16'h0002, 0, 0, 0, "csum");
        step(0, 16'h0000, 0, 0, 0, "csum");
        chk("csum.wrap1", {16'd0, o_checksum}, 32'h0005);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(3, 0) != 0, DW'($urandom), $urandom_range(9, 0) == 0,
                 $urandom_range(4, 0) < 2, $urandom_range(31, 0) == 0, "rand");
        end
        step(0, '0, 0, 0, 0, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
